// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;

  // Two-digit packed BCD constant from a binary value 0..99.
  function automatic logic [7:0] to_bcd8(input int value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/display bundle between the stopwatch counter and its neighbours.
// i_lap is present only when STOPWATCH_LAP_EN is defined.
interface stopwatch_counter_if;
  logic       i_basetick;
  logic       i_start_stop;
  logic       i_clear;
`ifdef STOPWATCH_LAP_EN
  logic       i_lap;
`endif
  logic       o_timerenb;
  logic       o_running;
  logic [7:0] o_cs_bcd;
  logic [7:0] o_sec_bcd;
  logic [7:0] o_min_bcd;
  logic       o_overflow;

`ifdef STOPWATCH_LAP_EN
  modport master (output i_basetick, i_start_stop, i_clear, i_lap,
                  input  o_timerenb, o_running, o_cs_bcd, o_sec_bcd, o_min_bcd, o_overflow);
  modport slave  (input  i_basetick, i_start_stop, i_clear, i_lap,
                  output o_timerenb, o_running, o_cs_bcd, o_sec_bcd, o_min_bcd, o_overflow);
`else
  modport master (output i_basetick, i_start_stop, i_clear,
                  input  o_timerenb, o_running, o_cs_bcd, o_sec_bcd, o_min_bcd, o_overflow);
  modport slave  (input  i_basetick, i_start_stop, i_clear,
                  output o_timerenb, o_running, o_cs_bcd, o_sec_bcd, o_min_bcd, o_overflow);
`endif
endinterface

// File: rtl/bcd_digit_counter.sv
// Single BCD digit, counts 0..MODULUS-1; carry is high on the increment that wraps.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic       i_sclk,
  input  logic       i_reset,
  input  logic       inc,
  input  logic       clear,
  output bcd_digit_t digit,
  output logic       carry
);

  localparam bcd_digit_t LAST = bcd_digit_t'(MODULUS - 1);

  assign carry = inc & (digit == LAST);

  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset)
      digit <= '0;
    else if (clear)
      digit <= '0;
    else if (inc)
      digit <= carry ? '0 : digit + 4'd1;
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch control FSM and BCD mm:ss.cc accumulator fed by the 10 ms base tick.
// Optional lap snapshot display enabled by STOPWATCH_LAP_EN.
//
// state | meaning
// IDLE  | stopped, time zeroed, timer held
// RUN   | timer enabled, ticks accumulate
// PAUSE | timer held, time preserved
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MINUTES = 59
) (
  input  logic              i_sclk,
  input  logic              i_reset,
  stopwatch_counter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_PAUSE = PAUSE;
  localparam logic [7:0] MIN_MAX_BCD = to_bcd8(MAX_MINUTES);

  logic [1:0] state_q, state_d;
  logic       bt_q, tick, count_en, running_q, overflow_q, wrap, min_clear;
  bcd_digit_t cs0, cs1, sec0, sec1, min0, min1;
  logic       c_cs0, c_cs1, c_sec0, c_sec1, c_min0, c_min1;
  logic [7:0] cs_live, sec_live, min_live;

  assign tick     = bus.i_basetick & ~bt_q;
  assign count_en = tick & (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_start_stop) state_d = S_RUN;
      S_RUN:   if (bus.i_start_stop) state_d = S_PAUSE;
      S_PAUSE: if (bus.i_start_stop) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (bus.i_clear)
      state_d = S_IDLE;
  end

  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      bt_q       <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bt_q       <= bus.i_basetick;
      running_q  <= (state_d == S_RUN);
      if (bus.i_clear)
        overflow_q <= 1'b0;
      else if (wrap)
        overflow_q <= 1'b1;
    end
  end

  // Minutes wrap as a pair at MAX_MINUTES, so they take a synchronous clear rather than a modulus.
  assign wrap      = c_sec1 & (min_live == MIN_MAX_BCD);
  assign min_clear = bus.i_clear | wrap;

  bcd_digit_counter #(.MODULUS(10))             u_cs0  (.i_sclk, .i_reset, .inc(count_en), .clear(bus.i_clear), .digit(cs0),  .carry(c_cs0));
  bcd_digit_counter #(.MODULUS(CS_MAX / 10 + 1))  u_cs1  (.i_sclk, .i_reset, .inc(c_cs0),    .clear(bus.i_clear), .digit(cs1),  .carry(c_cs1));
  bcd_digit_counter #(.MODULUS(10))             u_sec0 (.i_sclk, .i_reset, .inc(c_cs1),    .clear(bus.i_clear), .digit(sec0), .carry(c_sec0));
  bcd_digit_counter #(.MODULUS(SEC_MAX / 10 + 1)) u_sec1 (.i_sclk, .i_reset, .inc(c_sec0),   .clear(bus.i_clear), .digit(sec1), .carry(c_sec1));
  bcd_digit_counter #(.MODULUS(10))             u_min0 (.i_sclk, .i_reset, .inc(c_sec1),   .clear(min_clear),   .digit(min0), .carry(c_min0));
  bcd_digit_counter #(.MODULUS(10))             u_min1 (.i_sclk, .i_reset, .inc(c_min0),   .clear(min_clear),   .digit(min1), .carry(c_min1));

  assign cs_live  = {cs1, cs0};
  assign sec_live = {sec1, sec0};
  assign min_live = {min1, min0};

  assign bus.o_timerenb = running_q;
  assign bus.o_running  = running_q;
  assign bus.o_overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
  logic       freeze_q;
  logic [7:0] snap_cs, snap_sec, snap_min;

  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      freeze_q <= 1'b0;
      snap_cs  <= '0;
      snap_sec <= '0;
      snap_min <= '0;
    end else if (bus.i_clear || (state_q == S_RUN && bus.i_start_stop)) begin
      freeze_q <= 1'b0;
    end else if (state_q == S_RUN && bus.i_lap) begin
      freeze_q <= ~freeze_q;
      if (!freeze_q) begin
        snap_cs  <= cs_live;
        snap_sec <= sec_live;
        snap_min <= min_live;
      end
    end
  end

  assign bus.o_cs_bcd  = freeze_q ? snap_cs  : cs_live;
  assign bus.o_sec_bcd = freeze_q ? snap_sec : sec_live;
  assign bus.o_min_bcd = freeze_q ? snap_min : min_live;
`else
  assign bus.o_cs_bcd  = cs_live;
  assign bus.o_sec_bcd = sec_live;
  assign bus.o_min_bcd = min_live;
`endif

  logic unused_carry;
  assign unused_carry = c_min1;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; MAX_MINUTES is set to 1 so the wrap is reachable quickly.
module tb_stopwatch_counter;

  logic i_sclk = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   failures = 0;

  stopwatch_counter_if bus ();

  stopwatch_counter #(.MAX_MINUTES(1)) dut (
    .i_sclk  (i_sclk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_sclk = ~i_sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_sclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_basetick = 1'b1;
      step();
      bus.i_basetick = 1'b0;
      step();
    end
  endtask

  task automatic pulse_start();
    bus.i_start_stop = 1'b1;
    step();
    bus.i_start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
  endtask

  task automatic check_time(input string tag, input logic [7:0] m, input logic [7:0] s, input logic [7:0] c);
    check({tag, "_min"}, 32'(bus.o_min_bcd), 32'(m));
    check({tag, "_sec"}, 32'(bus.o_sec_bcd), 32'(s));
    check({tag, "_cs"},  32'(bus.o_cs_bcd),  32'(c));
  endtask

  initial begin
    i_reset          = 1'b1;
    bus.i_basetick   = 1'b0;
    bus.i_start_stop = 1'b0;
    bus.i_clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    bus.i_lap        = 1'b0;
`endif
    step();
    step();
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check("reset_timerenb", 32'(bus.o_timerenb), 32'd0);
    check("reset_running",  32'(bus.o_running),  32'd0);
    check("reset_overflow", 32'(bus.o_overflow), 32'd0);
    i_reset = 1'b0;
    step();

    // ticks in IDLE are not counted
    ticks(3);
    check_time("idle_ticks", 8'h00, 8'h00, 8'h00);

    pulse_start();
    check("start_running", 32'(bus.o_running), 32'd1);
    ticks(150);
    check_time("run150", 8'h00, 8'h01, 8'h50);
    check("run150_timerenb", 32'(bus.o_timerenb), 32'd1);

    pulse_clear();
    check_time("clear1", 8'h00, 8'h00, 8'h00);
    check("clear1_running", 32'(bus.o_running), 32'd0);

    // pause holds count while basetick keeps toggling
    pulse_start();
    ticks(37);
    pulse_start();
    check("pause_timerenb", 32'(bus.o_timerenb), 32'd0);
    ticks(20);
    check_time("pause20", 8'h00, 8'h00, 8'h37);
    check("pause20_timerenb", 32'(bus.o_timerenb), 32'd0);
    pulse_start();
    check("resume_timerenb", 32'(bus.o_timerenb), 32'd1);
    ticks(1);
    check_time("resume1", 8'h00, 8'h00, 8'h38);

    // basetick already high on entry to RUN does not count
    pulse_start();
    bus.i_basetick = 1'b1;
    step();
    step();
    pulse_start();
    step();
    step();
    check_time("level_high", 8'h00, 8'h00, 8'h38);
    bus.i_basetick = 1'b0;
    step();
    ticks(1);
    check_time("fresh_edge", 8'h00, 8'h00, 8'h39);

    // start_stop coincident with a tick in RUN
    bus.i_start_stop = 1'b1;
    bus.i_basetick   = 1'b1;
    step();
    bus.i_start_stop = 1'b0;
    bus.i_basetick   = 1'b0;
    check_time("stop_tick", 8'h00, 8'h00, 8'h40);
    check("stop_tick_running", 32'(bus.o_running), 32'd0);
    step();

    // clear, start_stop and tick together in RUN
    pulse_start();
    check("rerun_running", 32'(bus.o_running), 32'd1);
    bus.i_clear      = 1'b1;
    bus.i_start_stop = 1'b1;
    bus.i_basetick   = 1'b1;
    step();
    bus.i_clear      = 1'b0;
    bus.i_start_stop = 1'b0;
    bus.i_basetick   = 1'b0;
    check_time("clr_all", 8'h00, 8'h00, 8'h00);
    check("clr_all_running", 32'(bus.o_running), 32'd0);
    step();

    // reset mid-count
    pulse_start();
    ticks(5);
    check_time("pre_reset", 8'h00, 8'h00, 8'h05);
    i_reset = 1'b1;
    #1;
    check_time("async_reset", 8'h00, 8'h00, 8'h00);
    check("async_reset_running", 32'(bus.o_running), 32'd0);
    step();
    i_reset = 1'b0;
    ticks(3);
    check_time("post_reset", 8'h00, 8'h00, 8'h00);

    // minute carry, then wrap past 01:59.99
    pulse_start();
    ticks(5999);
    check_time("to_59_99", 8'h00, 8'h59, 8'h99);
    ticks(1);
    check_time("min_carry", 8'h01, 8'h00, 8'h00);
    check("min_carry_ovf", 32'(bus.o_overflow), 32'd0);
    ticks(5999);
    check_time("to_max", 8'h01, 8'h59, 8'h99);
    check("to_max_ovf", 32'(bus.o_overflow), 32'd0);
    ticks(1);
    check_time("wrap", 8'h00, 8'h00, 8'h00);
    check("wrap_ovf", 32'(bus.o_overflow), 32'd1);
    ticks(1);
    check_time("after_wrap", 8'h00, 8'h00, 8'h01);
    check("after_wrap_ovf", 32'(bus.o_overflow), 32'd1);
    pulse_clear();
    check("clear_ovf", 32'(bus.o_overflow), 32'd0);
    check("clear_idle", 32'(bus.o_running), 32'd0);
    check_time("clear2", 8'h00, 8'h00, 8'h00);

`ifdef STOPWATCH_LAP_EN
    pulse_start();
    ticks(100);
    bus.i_lap = 1'b1;
    step();
    bus.i_lap = 1'b0;
    ticks(50);
    check_time("lap_hold", 8'h00, 8'h01, 8'h00);
    bus.i_lap = 1'b1;
    step();
    bus.i_lap = 1'b0;
    check_time("lap_live", 8'h00, 8'h01, 8'h50);
    pulse_clear();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
